gate_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for a small combinational gate (e.g. AND2) in the pipeline datapath.
//  On start it walks all 2^N_IN input vectors, waits a settle window, samples the gate output
//  and compares it against a parameterised truth table. Reports pass/fail, error count and the

---
 rtl/gate_bist_pkg.sv | 17 +
 rtl/gate_bist_timer.sv | 35 +++
 rtl/gate_bist_ctrl.sv | 136 +++++++++++++
 tb/tb_gate_bist_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the combinational-gate BIST sequencer.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int CNT_W = 4;

  function automatic int nvec(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/gate_bist_timer.sv
// Settle-window down-counter: load starts a window, expired marks its last cycle.
module gate_bist_timer
  import gate_bist_pkg::*;
#(
  parameter int LOAD_VAL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks every input vector of a small gate, holds it for a settle
// window, then compares the gate output against the TRUTH table.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int                     N_IN         = 2,
  parameter logic [nvec(N_IN)-1:0]  TRUTH        = 4'b1000,
  parameter int                     SETTLE       = 1,
  parameter bit                     STOP_ON_FAIL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  state_e          state_q;
  logic [N_IN-1:0] vec_q;
  logic [N_IN-1:0] dut_in_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic [N_IN:0]   err_d;
  logic            fail_valid_q;
  logic [N_IN-1:0] first_fail_q;

  logic mismatch;
  logic last_vec;
  logic finish;
  logic tmr_load;
  logic tmr_en;
  logic tmr_expired;

  // X/Z on the gate output must count as a failure, hence the case inequality.
  assign mismatch = (dut_f !== TRUTH[vec_q]);
  assign last_vec = &vec_q;
  assign finish   = last_vec || (mismatch && STOP_ON_FAIL);
  assign err_d    = err_q + {{N_IN{1'b0}}, mismatch};

  always_comb begin
    tmr_load = 1'b0;
    case (state_q)
      IDLE:    tmr_load = start;
      CHECK:   tmr_load = !finish;
      default: tmr_load = 1'b0;
    endcase
  end

  assign tmr_en = (state_q == gate_bist_pkg::SETTLE);

  gate_bist_timer #(
    .LOAD_VAL (SETTLE - 1)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= gate_bist_pkg::SETTLE;
            vec_q        <= '0;
            dut_in_q     <= '0;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
          end
        end
        gate_bist_pkg::SETTLE: begin
          if (tmr_expired) state_q <= CHECK;
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            first_fail_q <= vec_q;
            fail_valid_q <= 1'b1;
          end
          // pass uses the count including this final check, so it is valid alongside done.
          if (finish) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            pass_q   <= (err_d == '0);
            dut_in_q <= '0;
          end else begin
            state_q  <= gate_bist_pkg::SETTLE;
            vec_q    <= vec_q + 1'b1;
            dut_in_q <= vec_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          dut_in_q <= '0;
        end
      endcase
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: three parameterisations driven by behavioural gate models.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: defaults (AND2, SETTLE=1)
  logic       start0;
  logic [1:0] din0, ff0;
  logic       f0, busy0, done0, pass0, fv0;
  logic [2:0] err0;
  // Instance 1: STOP_ON_FAIL=1
  logic       start1;
  logic [1:0] din1, ff1;
  logic       f1, busy1, done1, pass1, fv1;
  logic [2:0] err1;
  // Instance 2: SETTLE=3
  logic       start2;
  logic [1:0] din2, ff2;
  logic       f2, busy2, done2, pass2, fv2;
  logic [2:0] err2;

  int   mode0;      // 0: AND, 1: stuck-at-1, 2: AND delayed two cycles
  logic or_mode1;   // 1: instance 1 sees an OR gate
  logic [1:0] d0_1, d0_2, d2_1;
  int   seq [0:64];

  always @(posedge clk) begin
    d0_1 <= din0;
    d0_2 <= d0_1;
    d2_1 <= din2;
  end

  always_comb begin
    f0 = 1'b0;
    case (mode0)
      0:       f0 = din0[0] & din0[1];
      1:       f0 = 1'b1;
      default: f0 = d0_2[0] & d0_2[1];
    endcase
  end

  assign f1 = or_mode1 ? (din1[0] | din1[1]) : (din1[0] & din1[1]);
  assign f2 = d2_1[0] & d2_1[1];

  gate_bist_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_in(din0), .dut_f(f0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail(ff0)
  );

  gate_bist_ctrl #(.STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(din1), .dut_f(f1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail(ff1)
  );

  gate_bist_ctrl #(.SETTLE(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(din2), .dut_f(f2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .first_fail(ff2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  function automatic logic get_done(input int s);
    case (s)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // Pulses start for one cycle from the current falling edge and returns the number
  // of falling edges until done is seen (-1 on timeout); leaves time at that edge.
  task automatic run(input int s, output int lat);
    lat = -1;
    set_start(s, 1'b1);
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n == 1) set_start(s, 1'b0);
      if (s == 0) seq[n] = int'(din0);
      if (get_done(s)) begin
        lat = n;
        break;
      end
    end
    $display("run inst=%0d latency=%0d", s, lat);
  endtask

  initial begin
    int lat;
    int ndone, first, d1, d2, lowcnt;
    rst_n    = 1'b0;
    start0   = 1'b0;
    start1   = 1'b0;
    start2   = 1'b0;
    mode0    = 0;
    or_mode1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_fv", 32'(fv0), 32'd0);
    chk("rst_ff", 32'(ff0), 32'd0);
    chk("rst_din", 32'(din0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: golden AND2
    mode0 = 0;
    run(0, lat);
    chk("and_lat", 32'(lat), 32'd9);
    chk("and_pass", 32'(pass0), 32'd1);
    chk("and_err", 32'(err0), 32'd0);
    chk("and_fv", 32'(fv0), 32'd0);
    chk("and_busy_done", 32'(busy0), 32'd1);
    chk("and_din_done", 32'(din0), 32'd0);
    chk("and_seq1", 32'(seq[1]), 32'd0);
    chk("and_seq2", 32'(seq[2]), 32'd0);
    chk("and_seq3", 32'(seq[3]), 32'd1);
    chk("and_seq4", 32'(seq[4]), 32'd1);
    chk("and_seq5", 32'(seq[5]), 32'd2);
    chk("and_seq8", 32'(seq[8]), 32'd3);
    @(negedge clk);
    chk("and_done_pulse", 32'(done0), 32'd0);
    chk("and_busy_after", 32'(busy0), 32'd0);
    chk("and_pass_held", 32'(pass0), 32'd1);

    // 2: stuck-at-1 output
    mode0 = 1;
    run(0, lat);
    chk("sa1_lat", 32'(lat), 32'd9);
    chk("sa1_err", 32'(err0), 32'd3);
    chk("sa1_ff", 32'(ff0), 32'd0);
    chk("sa1_fv", 32'(fv0), 32'd1);
    chk("sa1_pass", 32'(pass0), 32'd0);
    @(negedge clk);

    // 3: stop-on-fail with an OR gate, then the same instance on a good gate
    or_mode1 = 1'b1;
    run(1, lat);
    chk("sof_lat", 32'(lat), 32'd5);
    chk("sof_err", 32'(err1), 32'd1);
    chk("sof_ff", 32'(ff1), 32'd1);
    chk("sof_fv", 32'(fv1), 32'd1);
    chk("sof_pass", 32'(pass1), 32'd0);
    @(negedge clk);
    or_mode1 = 1'b0;
    run(1, lat);
    chk("sof_good_lat", 32'(lat), 32'd9);
    chk("sof_good_pass", 32'(pass1), 32'd1);
    @(negedge clk);

    // 4: settle window vs delayed gate
    run(2, lat);
    chk("s3_lat", 32'(lat), 32'd17);
    chk("s3_pass", 32'(pass2), 32'd1);
    chk("s3_err", 32'(err2), 32'd0);
    @(negedge clk);
    mode0 = 2;
    run(0, lat);
    chk("dly2_lat", 32'(lat), 32'd9);
    chk("dly2_pass", 32'(pass0), 32'd0);
    chk("dly2_err", 32'(err0), 32'd1);
    chk("dly2_ff", 32'(ff0), 32'd3);
    @(negedge clk);

    // 5: asynchronous reset while vector 2 is applied
    mode0  = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_din", 32'(din0), 32'd2);
    chk("mid_err", 32'(err0), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_din", 32'(din0), 32'd0);
    chk("arst_err", 32'(err0), 32'd0);
    chk("arst_fv", 32'(fv0), 32'd0);
    chk("arst_ff", 32'(ff0), 32'd0);
    chk("arst_pass", 32'(pass0), 32'd0);
    chk("arst_done", 32'(done0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode0 = 0;
    @(negedge clk);
    run(0, lat);
    chk("post_rst_lat", 32'(lat), 32'd9);
    chk("post_rst_pass", 32'(pass0), 32'd1);
    @(negedge clk);

    // 6a: start re-pulsed while busy
    ndone  = 0;
    first  = 0;
    start0 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start0 = 1'b0;
      if (n == 3) start0 = 1'b1;
      if (n == 4) start0 = 1'b0;
      if (done0) begin
        ndone++;
        if (first == 0) first = n;
      end
    end
    $display("repulse dones=%0d first=%0d", ndone, first);
    chk("repulse_ndone", 32'(ndone), 32'd1);
    chk("repulse_first", 32'(first), 32'd9);

    // 6b: start held high gives back-to-back runs
    ndone  = 0;
    d1     = 0;
    d2     = 0;
    lowcnt = 0;
    start0 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done0) begin
        ndone++;
        if (ndone == 1) d1 = n;
        else if (ndone == 2) begin
          d2     = n;
          start0 = 1'b0;
        end
      end else if (ndone == 1 && !busy0) begin
        lowcnt++;
      end
    end
    start0 = 1'b0;
    $display("held dones=%0d d1=%0d d2=%0d idle_gap=%0d", ndone, d1, d2, lowcnt);
    chk("held_ndone", 32'(ndone), 32'd2);
    chk("held_d1", 32'(d1), 32'd9);
    chk("held_d2", 32'(d2), 32'd19);
    chk("held_gap", 32'(lowcnt), 32'd1);
    chk("held_pass", 32'(pass0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
